// File: rtl/fetch_hazard_ctrl.sv
// Fetch redirect/stall controller: load-use bubbles, memory freezes, branch
// redirects and replay of resolutions that arrive while the pipeline is stalled.
//
// state      | meaning
// RUN        | pipeline flowing, redirects issued directly
// LOAD_STALL | single load-use bubble cycle
// MEM_WAIT   | frozen on data memory, counting toward timeout
// RELEASE    | first cycle after a stall, deferred resolution replayed
module fetch_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_WAIT_MAX = 15,
  parameter int REG_ADDR_W   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  br_resolved,
  input  logic                  br_taken,
  input  logic [31:0]           br_target,
  input  logic                  mem_busy,
  output logic [1:0]            stall,
  output logic                  isBranchTaken,
  output logic [31:0]           branchPC,
  output logic [1:0]            stallC,
  output logic                  track,
  output logic                  flush,
  output logic                  mem_timeout
);

  localparam int WC_W = $clog2(MEM_WAIT_MAX + 2);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT, RELEASE} state_t;

  state_t          state;
  logic [WC_W-1:0] wait_cnt;
  logic [1:0]      flush_cnt;
  logic            pending_valid;
  logic            pending_taken;
  logic [31:0]     pending_target;

  logic            load_use;
  logic            eff_valid;
  logic            eff_taken;
  logic [31:0]     eff_target;

  always_comb begin
    load_use = ex_valid && ex_is_load && (ex_rd != '0) && id_valid &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    // A resolution arriving on the release edge supersedes the latched one
    eff_valid  = br_resolved || pending_valid;
    eff_taken  = br_resolved ? br_taken : pending_taken;
    eff_target = br_resolved ? br_target : pending_target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      wait_cnt       <= '0;
      flush_cnt      <= '0;
      pending_valid  <= 1'b0;
      pending_taken  <= 1'b0;
      pending_target <= '0;
      stall          <= 2'd0;
      isBranchTaken  <= 1'b0;
      branchPC       <= '0;
      stallC         <= 2'd0;
      track          <= 1'b0;
      flush          <= 1'b0;
      mem_timeout    <= 1'b0;
    end else begin
      isBranchTaken <= 1'b0;
      stallC        <= 2'd0;
      track         <= 1'b0;

      // Flush keeps draining regardless of any new freeze
      if (flush_cnt != '0) begin
        flush_cnt <= flush_cnt - 2'd1;
        flush     <= 1'b1;
      end else begin
        flush <= 1'b0;
      end

      case (state)
        RUN, RELEASE: begin
          if (mem_busy) begin
            state    <= MEM_WAIT;
            stall    <= 2'd2;
            wait_cnt <= WC_W'(1);
            if (br_resolved) begin
              pending_valid  <= 1'b1;
              pending_taken  <= br_taken;
              pending_target <= br_target;
            end
          end else if (br_resolved && br_taken) begin
            // The hazard instruction, if any, is wrong-path
            state         <= RUN;
            stall         <= 2'd0;
            isBranchTaken <= 1'b1;
            branchPC      <= br_target;
            flush         <= 1'b1;
            flush_cnt     <= 2'(FLUSH_CYCLES - 1);
          end else if (load_use) begin
            state <= LOAD_STALL;
            stall <= 2'd1;
          end else begin
            state <= RUN;
            stall <= 2'd0;
          end
        end

        LOAD_STALL, MEM_WAIT: begin
          if (br_resolved) begin
            pending_valid  <= 1'b1;
            pending_taken  <= br_taken;
            pending_target <= br_target;
          end
          if (state == MEM_WAIT && wait_cnt > WC_W'(MEM_WAIT_MAX))
            mem_timeout <= 1'b1;
          if (mem_busy) begin
            if (state == LOAD_STALL) begin
              state    <= MEM_WAIT;
              wait_cnt <= WC_W'(1);
            end else if (wait_cnt <= WC_W'(MEM_WAIT_MAX)) begin
              wait_cnt <= wait_cnt + WC_W'(1);
            end
            stall <= 2'd2;
          end else begin
            state         <= RELEASE;
            stall         <= 2'd0;
            wait_cnt      <= '0;
            pending_valid <= 1'b0;
            if (eff_valid && eff_taken) begin
              stallC    <= 2'd2;
              branchPC  <= eff_target;
              flush     <= 1'b1;
              flush_cnt <= 2'(FLUSH_CYCLES - 1);
            end else if (eff_valid) begin
              stallC <= 2'd1;
            end else begin
              track <= 1'b1;
            end
          end
        end

        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: doc/fetch_hazard_ctrl.md
Name: fetch_hazard_ctrl

Overview:
- Pipeline control block that generates the redirect/stall controls consumed by the fetch unit: stall, isBranchTaken, branchPC, stallC, track.
- Detects load-use hazards and memory-busy freezes, and accepts branch resolution from execute.
- Defers redirects that resolve during a stall and replays them on release; issues wrong-path flushes.
- Sits between decode/execute/memory stages and fetch in the 4-stage pipeline.

Parameters:
- FLUSH_CYCLES, 2: cycles flush is held after a taken redirect (1..3).
- MEM_WAIT_MAX, 15: max consecutive mem_busy cycles before mem_timeout sets.
- REG_ADDR_W, 5: register index width.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode stage holds a valid instruction
- id_rs1  in  REG_ADDR_W  decode source register 1
- id_rs2  in  REG_ADDR_W  decode source register 2
- id_use_rs1  in  1  decode reads rs1
- id_use_rs2  in  1  decode reads rs2
- ex_valid  in  1  execute stage valid
- ex_is_load  in  1  execute instruction is a load
- ex_rd  in  REG_ADDR_W  execute destination register
- br_resolved  in  1  execute resolved a branch/jump this cycle
- br_taken  in  1  resolution outcome (qualified by br_resolved)
- br_target  in  32  resolved target address
- mem_busy  in  1  data memory not ready; pipeline must freeze
- stall  out  2  0 = run, 1 = load-use bubble, 2 = memory freeze
- isBranchTaken  out  1  one-cycle redirect pulse (fetch loads branchPC)
- branchPC  out  32  redirect target
- stallC  out  2  deferred resolution replay: 2 = redirect, 1 = sequential resume, 0 = none
- track  out  1  one-cycle forced sequential increment after a plain stall release
- flush  out  1  squash wrong-path instructions in IF/ID
- mem_timeout  out  1  sticky error

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high. All outputs are registered.
- Reset values: stall=0, isBranchTaken=0, branchPC=0, stallC=0, track=0, flush=0, mem_timeout=0. FSM goes to RUN; pending flags and counters clear.
- Reset mid-operation discards any pending redirect and flush count.
- FSM states:
  - RUN
  - LOAD_STALL
  - MEM_WAIT
  - RELEASE
- Load-use hazard is true when ex_valid & ex_is_load & ex_rd!=0 & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- RUN transitions (priority order):
  - mem_busy -> MEM_WAIT, stall=2 next cycle.
  - Else load-use hazard -> LOAD_STALL, stall=1 next cycle.
  - Else stay in RUN, stall=0.
- LOAD_STALL:
  - Lasts exactly one cycle.
  - If mem_busy is also asserted, go to MEM_WAIT. Otherwise go to RELEASE.
- MEM_WAIT:
  - stall=2 while mem_busy. wait_cnt increments each cycle, saturating at MEM_WAIT_MAX+1.
  - When wait_cnt exceeds MEM_WAIT_MAX, set mem_timeout; it stays 1 until reset. The freeze continues.
  - When mem_busy drops: stall=0 next cycle, wait_cnt clears, go to RELEASE.
- RELEASE (one cycle; stall=0):
  - Pending taken: stallC=2, branchPC=pending target, flush starts.
  - Pending not-taken: stallC=1.
  - No pending resolution: track=1.
  - Then return to RUN, evaluating RUN rules in the same cycle.
- Branch resolution while stall==0 and not in RELEASE:
  - Taken: isBranchTaken=1 for one cycle next cycle, branchPC<=br_target, flush held FLUSH_CYCLES cycles.
  - Not taken: no outputs.
- Branch resolution while stall!=0:
  - Latch pending_valid, pending_taken and pending_target; no pulse.
  - A second resolution while pending overwrites the first.
- Simultaneous br_resolved and mem_busy in RUN: treated as stalled; the resolution is deferred.
- Simultaneous br_resolved and load-use hazard in RUN:
  - A taken branch has priority: no LOAD_STALL, since the hazard instruction is wrong-path.
  - A not-taken branch lets the load-use stall proceed.
- Flush during a new freeze: the flush counter keeps counting down.
- Mutual exclusivity: at most one of isBranchTaken, stallC!=0 and track is nonzero in any cycle.
- branchPC holds its last value between redirects.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> stall=1 for 1 cycle, then track=1 for 1 cycle, then stall=0.
- Load-use with ex_rd=0: same stimulus -> stall stays 0, track stays 0.
- Taken branch in RUN: br_resolved=1, br_taken=1, br_target=0x40 -> next cycle isBranchTaken=1 and branchPC=0x40; flush=1 for exactly 2 cycles.
- Deferred taken: mem_busy for 3 cycles; br_resolved taken to 0x80 during the 2nd cycle -> stall=2 throughout, no isBranchTaken; on release stallC=2, branchPC=0x80, flush for 2 cycles.
- Deferred not-taken during load stall -> stallC=1 for 1 cycle on release, track=0, flush=0.
- Timeout: mem_busy held 20 cycles -> mem_timeout=1 from the 17th stalled cycle onward and stays 1 after mem_busy drops; reset in the next cycle -> all outputs return to 0.
